// File: rtl/equiv_miter_monitor.sv
// Clocked equivalence monitor for miter harnesses: aligns two design copies,
// masks a warm-up window, and reports sticky fail, counters and first-diff capture.
module equiv_miter_monitor #(
    parameter int WIDTH        = 91,
    parameter int SKEW         = 0,
    parameter int WARMUP       = 2,
    parameter int CNT_W        = 16,
    parameter int STOP_ON_FAIL = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [WIDTH-1:0] y_1,
    input  logic [WIDTH-1:0] y_2,
    output logic             fail,
    output logic [CNT_W-1:0] mismatch_cnt,
    output logic [CNT_W-1:0] cmp_idx,
    output logic [CNT_W-1:0] first_idx,
    output logic [WIDTH-1:0] first_diff,
    output logic [1:0]       state,
    output logic             checking
);

    typedef enum logic [1:0] {
        ST_WARM  = 2'd0,
        ST_CHECK = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    localparam state_t ST_RST = (WARMUP == 0) ? ST_CHECK : ST_WARM;

    state_t           state_q, state_d;
    logic             fail_q, fail_d;
    logic [CNT_W-1:0] mcnt_q, mcnt_d;
    logic [CNT_W-1:0] cidx_q, cidx_d;
    logic [CNT_W-1:0] fidx_q, fidx_d;
    logic [WIDTH-1:0] fdiff_q, fdiff_d;
    logic [7:0]       warm_q, warm_d;

    logic [WIDTH-1:0] y_1_d;
    logic             en_d;
    logic             valid;
    logic             miss;

    generate
        if (SKEW == 0) begin : g_wire
            assign y_1_d = y_1;
            assign en_d  = en;
        end else begin : g_dly
            logic [WIDTH-1:0] dly_y_q [SKEW];
            logic [WIDTH-1:0] dly_y_d [SKEW];
            logic [SKEW-1:0]  dly_en_q, dly_en_d;

            // The line holds still while halted so the failing context stays visible
            always_comb begin
                dly_y_d  = dly_y_q;
                dly_en_d = dly_en_q;
                if (state_q != ST_HALT) begin
                    dly_y_d[0]  = y_1;
                    dly_en_d[0] = en;
                    for (int i = 1; i < SKEW; i++) begin
                        dly_y_d[i]  = dly_y_q[i-1];
                        dly_en_d[i] = dly_en_q[i-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    dly_y_q  <= '{default: '0};
                    dly_en_q <= '0;
                end else begin
                    dly_y_q  <= dly_y_d;
                    dly_en_q <= dly_en_d;
                end
            end

            assign y_1_d = dly_y_q[SKEW-1];
            assign en_d  = dly_en_q[SKEW-1];
        end
    endgenerate

    assign valid = en_d && (state_q != ST_HALT);
    assign miss  = (y_1_d != y_2);

    always_comb begin
        state_d = state_q;
        fail_d  = fail_q;
        mcnt_d  = mcnt_q;
        cidx_d  = cidx_q;
        fidx_d  = fidx_q;
        fdiff_d = fdiff_q;
        warm_d  = warm_q;
        if (valid) begin
            if (cidx_q != '1) cidx_d = cidx_q + CNT_W'(1);
            unique case (state_q)
                ST_WARM: begin
                    warm_d = warm_q + 8'd1;
                    if (warm_q == 8'(WARMUP - 1)) state_d = ST_CHECK;
                end
                ST_CHECK: begin
                    if (miss) begin
                        if (mcnt_q != '1) mcnt_d = mcnt_q + CNT_W'(1);
                        if (!fail_q) begin
                            fail_d  = 1'b1;
                            fidx_d  = cidx_q;
                            fdiff_d = y_1_d ^ y_2;
                        end
                        if (STOP_ON_FAIL != 0) state_d = ST_HALT;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RST;
            fail_q  <= 1'b0;
            mcnt_q  <= '0;
            cidx_q  <= '0;
            fidx_q  <= '0;
            fdiff_q <= '0;
            warm_q  <= '0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
            mcnt_q  <= mcnt_d;
            cidx_q  <= cidx_d;
            fidx_q  <= fidx_d;
            fdiff_q <= fdiff_d;
            warm_q  <= warm_d;
        end
    end

    assign fail         = fail_q;
    assign mismatch_cnt = mcnt_q;
    assign cmp_idx      = cidx_q;
    assign first_idx    = fidx_q;
    assign first_diff   = fdiff_q;
    assign state        = state_q;
    assign checking     = (state_q == ST_CHECK);

`ifdef FORMAL
    // The miter verdict: the two copies must never diverge
    a_no_fail: assert property (@(posedge clk) !fail);
`elsif EQUIV_MITER_ASSERT
    // The miter verdict: the two copies must never diverge
    a_no_fail: assert property (@(posedge clk) !fail);
`endif

endmodule

// File: tb/tb_equiv_miter_monitor.sv
// Directed bench for equiv_miter_monitor: table vectors plus multi-cycle
// scenarios across several parameterisations sharing one stimulus bus.
module tb_equiv_miter_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [90:0] y_1;
    logic [90:0] y_2;

    // 0: defaults, 1: SKEW=3, 2: SKEW=2, 3: continue mode
    logic        fl [4];
    logic [15:0] mc [4];
    logic [15:0] ci [4];
    logic [15:0] fi [4];
    logic [90:0] fd [4];
    logic [1:0]  st [4];
    logic        ck [4];

    // saturation instance, CNT_W=4, WARMUP=0
    logic        fl4;
    logic [3:0]  mc4, ci4, fi4;
    logic [90:0] fd4;
    logic [1:0]  st4;
    logic        ck4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    equiv_miter_monitor u_base (
        .clk(clk), .rst(rst), .en(en), .y_1(y_1), .y_2(y_2),
        .fail(fl[0]), .mismatch_cnt(mc[0]), .cmp_idx(ci[0]),
        .first_idx(fi[0]), .first_diff(fd[0]), .state(st[0]),
        .checking(ck[0])
    );

    equiv_miter_monitor #(.SKEW(3)) u_sk3 (
        .clk(clk), .rst(rst), .en(en), .y_1(y_1), .y_2(y_2),
        .fail(fl[1]), .mismatch_cnt(mc[1]), .cmp_idx(ci[1]),
        .first_idx(fi[1]), .first_diff(fd[1]), .state(st[1]),
        .checking(ck[1])
    );

    equiv_miter_monitor #(.SKEW(2)) u_sk2 (
        .clk(clk), .rst(rst), .en(en), .y_1(y_1), .y_2(y_2),
        .fail(fl[2]), .mismatch_cnt(mc[2]), .cmp_idx(ci[2]),
        .first_idx(fi[2]), .first_diff(fd[2]), .state(st[2]),
        .checking(ck[2])
    );

    equiv_miter_monitor #(.STOP_ON_FAIL(0)) u_cont (
        .clk(clk), .rst(rst), .en(en), .y_1(y_1), .y_2(y_2),
        .fail(fl[3]), .mismatch_cnt(mc[3]), .cmp_idx(ci[3]),
        .first_idx(fi[3]), .first_diff(fd[3]), .state(st[3]),
        .checking(ck[3])
    );

    equiv_miter_monitor #(.CNT_W(4), .WARMUP(0), .STOP_ON_FAIL(0)) u_sat (
        .clk(clk), .rst(rst), .en(en), .y_1(y_1), .y_2(y_2),
        .fail(fl4), .mismatch_cnt(mc4), .cmp_idx(ci4),
        .first_idx(fi4), .first_diff(fd4), .state(st4),
        .checking(ck4)
    );

    typedef struct {
        logic        en;
        logic [90:0] y1;
        logic [90:0] y2;
        logic        fail;
        logic [15:0] mc;
        logic [15:0] ci;
        logic [15:0] fi;
        logic [90:0] fd;
        logic [1:0]  st;
    } vec_t;

    vec_t tbl [8];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        en  = 1'b0;
        y_1 = '0;
        y_2 = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic chk(input string nm, input logic [90:0] act,
                       input logic [90:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [90:0] vec(input int t);
        return {27'h5a5a5a5 ^ 27'(t), 32'(t * 37 + 11), 32'(t * 1103 + 7)};
    endfunction

    function automatic logic [90:0] dmask(input int i);
        return {1'b1, 90'(i + 1)};
    endfunction

    initial begin
        int first_rise;
        logic [90:0] r;

        tbl[0] = '{1'b1, 91'h1, 91'h2, 1'b0, 16'd0, 16'd1, 16'd0, 91'h0, 2'd0};
        tbl[1] = '{1'b0, 91'h3, 91'h4, 1'b0, 16'd0, 16'd1, 16'd0, 91'h0, 2'd0};
        tbl[2] = '{1'b1, 91'h5, 91'h6, 1'b0, 16'd0, 16'd2, 16'd0, 91'h0, 2'd1};
        tbl[3] = '{1'b1, 91'h7, 91'h7, 1'b0, 16'd0, 16'd3, 16'd0, 91'h0, 2'd1};
        tbl[4] = '{1'b0, 91'h0, 91'h9, 1'b0, 16'd0, 16'd3, 16'd0, 91'h0, 2'd1};
        tbl[5] = '{1'b1, 91'hA, 91'h3, 1'b1, 16'd1, 16'd4, 16'd3, 91'h9, 2'd2};
        tbl[6] = '{1'b1, 91'h1, 91'h2, 1'b1, 16'd1, 16'd4, 16'd3, 91'h9, 2'd2};
        tbl[7] = '{1'b0, 91'h1, 91'h2, 1'b1, 16'd1, 16'd4, 16'd3, 91'h9, 2'd2};

        do_reset();
        chk("rst_fail", fl[0], 0);
        chk("rst_mc", mc[0], 0);
        chk("rst_ci", ci[0], 0);
        chk("rst_fi", fi[0], 0);
        chk("rst_fd", fd[0], 0);
        chk("rst_st", st[0], 0);
        chk("rst_ck", ck[0], 0);
        chk("rst_sk3_fd", fd[1], 0);
        chk("rst_w0_st", st4, 1);
        chk("rst_w0_ck", ck4, 1);

        for (int i = 0; i < 8; i++) begin
            en  = tbl[i].en;
            y_1 = tbl[i].y1;
            y_2 = tbl[i].y2;
            tick();
            chk($sformatf("tbl%0d_fail", i), fl[0], tbl[i].fail);
            chk($sformatf("tbl%0d_mc", i), mc[0], tbl[i].mc);
            chk($sformatf("tbl%0d_ci", i), ci[0], tbl[i].ci);
            chk($sformatf("tbl%0d_fi", i), fi[0], tbl[i].fi);
            chk($sformatf("tbl%0d_fd", i), fd[0], tbl[i].fd);
            chk($sformatf("tbl%0d_st", i), st[0], tbl[i].st);
        end

        // warm-up masking then first unmasked mismatch
        do_reset();
        en = 1'b1; y_1 = 91'h1; y_2 = 91'h2;
        tick();
        y_1 = 91'h3; y_2 = 91'h0;
        tick();
        chk("warm_fail", fl[0], 0);
        chk("warm_mc", mc[0], 0);
        chk("warm_st", st[0], 1);
        y_1 = 91'h0; y_2 = 91'h5;
        tick();
        chk("warm_hit_fail", fl[0], 1);
        chk("warm_hit_fi", fi[0], 2);
        chk("warm_hit_fd", fd[0], 91'h5);
        chk("warm_hit_st", st[0], 2);
        chk("warm_hit_mc", mc[0], 1);

        // long matching run
        do_reset();
        for (int i = 0; i < 100; i++) begin
            r = {$urandom(), $urandom(), $urandom()};
            en = 1'b1; y_1 = r; y_2 = r;
            tick();
        end
        en = 1'b0;
        chk("match_fail", fl[0], 0);
        chk("match_mc", mc[0], 0);
        chk("match_ci", ci[0], 100);
        chk("match_st", st[0], 1);
        chk("match_ck", ck[0], 1);

        // skew alignment: y_2 lags y_1 by 3
        do_reset();
        first_rise = -1;
        for (int t = 0; t < 20; t++) begin
            en  = 1'b1;
            y_1 = vec(t);
            y_2 = (t >= 3) ? vec(t - 3) : '0;
            tick();
            if (fl[2] && first_rise < 0) first_rise = t;
        end
        en = 1'b0;
        chk("sk3_fail", fl[1], 0);
        chk("sk3_ci", ci[1], 17);
        chk("sk3_st", st[1], 1);
        chk("sk3_ck", ck[1], 1);
        chk("sk2_fail", fl[2], 1);
        chk("sk2_fi", fi[2], 2);
        chk("sk2_fd", fd[2], vec(2) ^ vec(1));
        chk("sk2_rise", 91'(first_rise), 4);
        chk("sk2_mc", mc[2], 1);
        chk("sk2_ci", ci[2], 3);
        chk("sk2_ck", ck[2], 0);

        // continue mode; a masked mismatch at 0 and an idle cycle with bad data
        do_reset();
        for (int i = 0; i < 25; i++) begin
            if (i == 12) begin
                en = 1'b0; y_1 = '0; y_2 = '1;
                tick();
            end
            en  = 1'b1;
            y_1 = vec(i);
            y_2 = vec(i);
            if (i == 0 || i == 4 || i == 7 || i == 9 || i == 10 || i == 20)
                y_2 = vec(i) ^ dmask(i);
            tick();
        end
        en = 1'b0;
        chk("cont_fail", fl[3], 1);
        chk("cont_mc", mc[3], 5);
        chk("cont_ci", ci[3], 25);
        chk("cont_fi", fi[3], 4);
        chk("cont_fd", fd[3], dmask(4));
        chk("cont_st", st[3], 1);
        chk("cont_ck", ck[3], 1);

        // saturation with 4-bit counters
        do_reset();
        for (int i = 0; i < 20; i++) begin
            en = 1'b1; y_1 = '0; y_2 = 91'h1;
            tick();
            if (i == 14) begin
                chk("sat15_mc", mc4, 15);
                chk("sat15_ci", ci4, 15);
            end
        end
        en = 1'b0;
        chk("sat_mc", mc4, 15);
        chk("sat_ci", ci4, 15);
        chk("sat_fi", fi4, 0);
        chk("sat_fd", fd4, 91'h1);
        chk("sat_fail", fl4, 1);
        chk("sat_st", st4, 1);

        // reset with a mismatch and samples in flight
        do_reset();
        for (int t = 0; t < 6; t++) begin
            en  = 1'b1;
            y_1 = vec(t);
            y_2 = (t >= 3) ? vec(t - 3) : '0;
            tick();
        end
        chk("mid_pre_st", st[1], 1);
        chk("mid_pre_ci", ci[1], 3);
        en  = 1'b1;
        y_1 = vec(6);
        y_2 = ~vec(3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_fail", fl[1], 0);
        chk("mid_mc", mc[1], 0);
        chk("mid_ci", ci[1], 0);
        chk("mid_fi", fi[1], 0);
        chk("mid_fd", fd[1], 0);
        chk("mid_st", st[1], 0);
        chk("mid_ck", ck[1], 0);
        en  = 1'b0;
        y_1 = '0;
        y_2 = '1;
        repeat (5) tick();
        chk("flush_ci", ci[1], 0);
        chk("flush_fail", fl[1], 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
